// File: rtl/mem_watch_pkg.sv
// Shared sizing helpers for the data-memory watch unit.
// An event is packed as {ch, data, ts}, with ch at the MSB end.
package mem_watch_pkg;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int ev_w(input int num_ch, input int data_w, input int ts_w);
    return ch_w(num_ch) + data_w + ts_w;
  endfunction

  // Low bit of channel ch inside the flattened shadow window.
  function automatic int slice_lo(input int ch, input int data_w);
    return ch * data_w;
  endfunction

endpackage

// File: rtl/watch_fifo.sv
// Synchronous event FIFO. An extra pointer bit tells full from empty.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module watch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads zero when empty so the event fields are clean after reset.
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/mem_watch.sv
// Data-memory watch unit: shadows a window of addresses and queues
// timestamped change events; flags completion after a quiet period.
module mem_watch
  import mem_watch_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int BASE       = 8,
  parameter int NUM_CH     = 20,
  parameter int DEPTH      = 16,
  parameter int TS_W       = 32,
  parameter int IDLE_LIMIT = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [NUM_CH*DATA_W-1:0]   mem_flat,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [ch_w(NUM_CH)-1:0]    ev_ch,
  output logic [DATA_W-1:0]          ev_data,
  output logic [TS_W-1:0]            ev_time,
  output logic                       overflow,
  output logic                       done
);
  localparam int CW = ch_w(NUM_CH);
  localparam int EW = ev_w(NUM_CH, DATA_W, TS_W);
  localparam int IW = $clog2(IDLE_LIMIT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_LIMIT);

  logic [NUM_CH*DATA_W-1:0] shadow;
  logic [TS_W-1:0]          ts;
  logic [IW-1:0]            idle;
  logic [31:0]              offset;
  logic [CW-1:0]            ch;
  logic [DATA_W-1:0]        old;
  logic                     hit;
  logic                     change;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic [EW-1:0]            ev_in;
  logic [EW-1:0]            ev_out;

  assign offset = 32'(wr_addr) - 32'(BASE);
  assign hit    = wr_en && (32'(wr_addr) >= 32'(BASE)) && (offset < 32'(NUM_CH));
  assign ch     = CW'(offset);
  assign old    = shadow[slice_lo(int'(ch), DATA_W) +: DATA_W];
  assign change = hit && (wr_data != old);
  assign pop    = !empty && ev_ready;
  assign ev_in  = {ch, wr_data, ts};

  watch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (change),
    .din   (ev_in),
    .pop   (pop),
    .dout  (ev_out),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow   <= '0;
      ts       <= '0;
      idle     <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (hit) shadow[slice_lo(int'(ch), DATA_W) +: DATA_W] <= wr_data;
      if (ts != '1) ts <= ts + 1'b1;
      if (change && full && !pop) overflow <= 1'b1;
      // Same-value rewrites do not count as activity for the idle timer.
      if (change) begin
        idle <= '0;
      end else if (idle != IDLE_MAX) begin
        idle <= idle + 1'b1;
        if (idle == IDLE_MAX - 1'b1) done <= 1'b1;
      end
    end
  end

  assign mem_flat = shadow;
  assign ev_valid = !empty;
  assign ev_ch    = ev_out[EW-1 -: CW];
  assign ev_data  = ev_out[TS_W +: DATA_W];
  assign ev_time  = ev_out[TS_W-1:0];

endmodule
